mc_ctrl: RTL

Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the ALUOp code and the datapath strobes into the ALU, register file, PC, IR and data memory. It is the initiator of the ALUOp/Compare interface: it issues the operation and samples Compare for branch resolution. Memory accesses use a ready handshake so that wait-stated memories stall the sequence.

---
 rtl/mc_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit (FETCH -> DCD -> EXE -> MEM -> WB).
// Latency (zero wait): j/jal/jr 2, branch 3, sw 4, R/I ALU 4, lw 5 cycles.
// Backpressure: FETCH holds on im_ready=0, MEM holds on dm_ready=0 with the request held.
// Ports: clk/rst (sync, active-high); Op/Funct/Rt from IR; Compare = ALU bit 0;
//        im_ready/dm_ready memory handshakes; PCWr/IRWr/RFWr/DMWr/DMRd strobes;
//        ALUOp/ALUSrcA/ALUSrcB/ExtOp to the ALU; NPCOp/WDSel/GPRSel muxes; Illegal pulse.
module mc_ctrl #(
    parameter int RA_IDX = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    input  logic       Compare,
    input  logic       im_ready,
    input  logic       dm_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic       DMRd,
    output logic [4:0] ALUOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] NPCOp,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic       Illegal
);

    // ALU operation encodings shared with the datapath ALU.
    localparam logic [4:0] ALUOp_NOP  = 5'd0,  ALUOp_ADD  = 5'd1,  ALUOp_ADDU = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3,  ALUOp_SUBU = 5'd4,  ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6,  ALUOp_XOR  = 5'd7,  ALUOp_NOR  = 5'd8;
    localparam logic [4:0] ALUOp_SLT  = 5'd9,  ALUOp_SLTU = 5'd10, ALUOp_SLL  = 5'd11;
    localparam logic [4:0] ALUOp_SRL  = 5'd12, ALUOp_SRA  = 5'd13, ALUOp_EQL  = 5'd14;
    localparam logic [4:0] ALUOp_BNE  = 5'd15, ALUOp_GT0  = 5'd16, ALUOp_LE0  = 5'd17;
    localparam logic [4:0] ALUOp_LT0  = 5'd18, ALUOp_GE0  = 5'd19;

    // The register index for jal is applied in the datapath (GPRSel=2);
    // it must still be a valid 5-bit register number.
    if (RA_IDX < 0 || RA_IDX > 31) begin : g_ra_idx_out_of_range
        localparam int RA_IDX_INVALID = RA_IDX;
    end

    typedef enum logic [2:0] {S_FETCH, S_DCD, S_EXE, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {C_ILL, C_RALU, C_IALU, C_LUI, C_LW, C_SW,
                              C_BR, C_J, C_JAL, C_JR} cls_t;

    state_t     state_q;
    cls_t       cls;
    logic [4:0] dec_alu;
    logic       dec_srca;
    logic       dec_srcb;
    logic       dec_ext;

    // Instruction class and ALU controls; IR is stable for the whole instruction.
    always_comb begin
        cls      = C_ILL;
        dec_alu  = ALUOp_NOP;
        dec_srca = 1'b0;
        dec_srcb = 1'b0;
        dec_ext  = 1'b0;
        case (Op)
            6'h00: begin
                cls = C_RALU;
                case (Funct)
                    6'h00: begin dec_alu = ALUOp_SLL; dec_srca = 1'b1; end
                    6'h02: begin dec_alu = ALUOp_SRL; dec_srca = 1'b1; end
                    6'h03: begin dec_alu = ALUOp_SRA; dec_srca = 1'b1; end
                    6'h04: dec_alu = ALUOp_SLL;
                    6'h06: dec_alu = ALUOp_SRL;
                    6'h07: dec_alu = ALUOp_SRA;
                    6'h08: cls = C_JR;
                    6'h20: dec_alu = ALUOp_ADD;
                    6'h21: dec_alu = ALUOp_ADDU;
                    6'h22: dec_alu = ALUOp_SUB;
                    6'h23: dec_alu = ALUOp_SUBU;
                    6'h24: dec_alu = ALUOp_AND;
                    6'h25: dec_alu = ALUOp_OR;
                    6'h26: dec_alu = ALUOp_XOR;
                    6'h27: dec_alu = ALUOp_NOR;
                    6'h2A: dec_alu = ALUOp_SLT;
                    6'h2B: dec_alu = ALUOp_SLTU;
                    default: cls = C_ILL;
                endcase
            end
            6'h01: begin
                // REGIMM: Rt picks bltz/bgez, anything else is undecoded.
                cls = C_BR;
                if (Rt == 5'd0)      dec_alu = ALUOp_LT0;
                else if (Rt == 5'd1) dec_alu = ALUOp_GE0;
                else                 cls = C_ILL;
            end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h04: begin cls = C_BR; dec_alu = ALUOp_EQL; end
            6'h05: begin cls = C_BR; dec_alu = ALUOp_BNE; end
            6'h06: begin cls = C_BR; dec_alu = ALUOp_LE0; end
            6'h07: begin cls = C_BR; dec_alu = ALUOp_GT0; end
            6'h08: begin cls = C_IALU; dec_alu = ALUOp_ADD;  dec_srcb = 1'b1; dec_ext = 1'b1; end
            6'h09: begin cls = C_IALU; dec_alu = ALUOp_ADDU; dec_srcb = 1'b1; dec_ext = 1'b1; end
            6'h0A: begin cls = C_IALU; dec_alu = ALUOp_SLT;  dec_srcb = 1'b1; dec_ext = 1'b1; end
            6'h0B: begin cls = C_IALU; dec_alu = ALUOp_SLTU; dec_srcb = 1'b1; dec_ext = 1'b1; end
            6'h0C: begin cls = C_IALU; dec_alu = ALUOp_AND;  dec_srcb = 1'b1; end
            6'h0D: begin cls = C_IALU; dec_alu = ALUOp_OR;   dec_srcb = 1'b1; end
            6'h0E: begin cls = C_IALU; dec_alu = ALUOp_XOR;  dec_srcb = 1'b1; end
            // lui: ALU passes B through; the datapath shifts imm16 into the upper half.
            6'h0F: begin cls = C_LUI;  dec_alu = ALUOp_NOP;  dec_srcb = 1'b1; end
            6'h23: begin cls = C_LW;   dec_alu = ALUOp_ADD;  dec_srcb = 1'b1; dec_ext = 1'b1; end
            6'h2B: begin cls = C_SW;   dec_alu = ALUOp_ADD;  dec_srcb = 1'b1; dec_ext = 1'b1; end
            default: cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: if (im_ready) state_q <= S_DCD;
                S_DCD: begin
                    case (cls)
                        C_J, C_JAL, C_JR, C_ILL: state_q <= S_FETCH;
                        default:                 state_q <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (cls)
                        C_LW, C_SW: state_q <= S_MEM;
                        C_BR:       state_q <= S_FETCH;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM: if (dm_ready) state_q <= (cls == C_LW) ? S_WB : S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Moore strobes from state_q, qualified by the ready/Compare inputs.
    // Forced low while rst is high so an abandoned store never writes.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        DMRd    = 1'b0;
        ALUOp   = ALUOp_NOP;
        ALUSrcA = 1'b0;
        ALUSrcB = 1'b0;
        ExtOp   = 1'b0;
        NPCOp   = 2'd0;
        WDSel   = 2'd0;
        GPRSel  = 2'd0;
        Illegal = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWr = im_ready;
                    PCWr = im_ready;
                end
                S_DCD: begin
                    case (cls)
                        C_J:   begin PCWr = 1'b1; NPCOp = 2'd2; end
                        C_JAL: begin
                            PCWr   = 1'b1;
                            NPCOp  = 2'd2;
                            RFWr   = 1'b1;
                            GPRSel = 2'd2;
                            WDSel  = 2'd2;
                        end
                        C_JR:  begin PCWr = 1'b1; NPCOp = 2'd3; end
                        C_ILL: Illegal = 1'b1;
                        default: ;
                    endcase
                end
                S_EXE: begin
                    ALUOp   = dec_alu;
                    ALUSrcA = dec_srca;
                    ALUSrcB = dec_srcb;
                    ExtOp   = dec_ext;
                    if (cls == C_BR && Compare) begin
                        PCWr  = 1'b1;
                        NPCOp = 2'd1;
                    end
                end
                S_MEM: begin
                    DMRd = (cls == C_LW);
                    DMWr = (cls == C_SW);
                end
                S_WB: begin
                    RFWr   = 1'b1;
                    WDSel  = (cls == C_LW) ? 2'd1 : 2'd0;
                    GPRSel = (cls == C_RALU) ? 2'd0 : 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
